// File: rtl/buffer_read_job_scheduler.sv
// Read-job scheduler: queues {cache-line address, length} descriptors and
// sequences the buffer-fill reader (run pulse, stable operands, wait for done).
module buffer_read_job_scheduler #(
  parameter int unsigned QUEUE_DEPTH   = 4,
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned CL_ADDR_WIDTH = 42
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             enable_i,
  input  logic                             job_valid_i,
  output logic                             job_ready_o,
  input  logic [CL_ADDR_WIDTH-1:0]         job_clAddr_i,
  input  logic [63:0]                      job_length_i,
  output logic                             rd_run_o,
  output logic [CL_ADDR_WIDTH-1:0]         rd_first_clAddr_o,
  output logic [63:0]                      rd_data_length_o,
  input  logic                             rd_done_i,
  output logic                             busy_o,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_count_o,
  output logic                             cmpl_valid_o,
  output logic [CL_ADDR_WIDTH-1:0]         cmpl_clAddr_o,
  output logic [COUNT_WIDTH-1:0]           jobs_done_o
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LEN_W = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    ARM       = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       rd_run_q, rd_run_d;
  logic [CL_ADDR_WIDTH-1:0]   first_q, first_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic                       cmpl_valid_q, cmpl_valid_d;
  logic [CL_ADDR_WIDTH-1:0]   cmpl_addr_q, cmpl_addr_d;
  logic [COUNT_WIDTH-1:0]     jobs_q, jobs_d;

  logic [CL_ADDR_WIDTH-1:0]   addr_mem [QUEUE_DEPTH];
  logic [LEN_W-1:0]           len_mem  [QUEUE_DEPTH];

  logic                       push_c;
  logic                       pop_c;
  logic [CL_ADDR_WIDTH-1:0]   head_addr_c;
  logic [LEN_W-1:0]           head_len_c;

  assign job_ready_o   = (count_q != CNT_W'(QUEUE_DEPTH));
  assign push_c        = job_valid_i && job_ready_o;
  assign head_addr_c   = addr_mem[rd_ptr_q];
  assign head_len_c    = len_mem[rd_ptr_q];
  assign busy_o        = (state_q != IDLE) || (count_q != '0);
  assign queue_count_o = count_q;

  assign rd_run_o          = rd_run_q;
  assign rd_first_clAddr_o = first_q;
  assign rd_data_length_o  = len_q;
  assign cmpl_valid_o      = cmpl_valid_q;
  assign cmpl_clAddr_o     = cmpl_addr_q;
  assign jobs_done_o       = jobs_q;

  // Descriptor storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      addr_mem[wr_ptr_q] <= job_clAddr_i;
      len_mem[wr_ptr_q]  <= job_length_i;
    end
  end

  // Next-state, reader operands and completion reporting.
  always_comb begin
    state_d      = state_q;
    rd_run_d     = 1'b0;
    first_d      = first_q;
    len_d        = len_q;
    cmpl_valid_d = 1'b0;
    cmpl_addr_d  = cmpl_addr_q;
    jobs_d       = jobs_q;
    pop_c        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && (count_q != '0)) begin
          pop_c   = 1'b1;
          first_d = head_addr_c;
          len_d   = head_len_c;
          if (head_len_c != '0) begin
            state_d  = LAUNCH;
            rd_run_d = 1'b1;
          end else begin
            // Zero-length job completes without involving the reader.
            cmpl_valid_d = 1'b1;
            cmpl_addr_d  = head_addr_c;
            jobs_d       = jobs_q + COUNT_WIDTH'(1);
          end
        end
      end
      LAUNCH: state_d = ARM;
      // Reader's done still reflects the previous job here; ignore it.
      ARM: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (rd_done_i) begin
          state_d      = IDLE;
          cmpl_valid_d = 1'b1;
          cmpl_addr_d  = first_q;
          jobs_d       = jobs_q + COUNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_run_q     <= 1'b0;
      first_q      <= '0;
      len_q        <= '0;
      cmpl_valid_q <= 1'b0;
      cmpl_addr_q  <= '0;
      jobs_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_run_q     <= rd_run_d;
      first_q      <= first_d;
      len_q        <= len_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_addr_q  <= cmpl_addr_d;
      jobs_q       <= jobs_d;
    end
  end

endmodule
